// File: rtl/dpll_loop_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// dpll_loop_sequencer_pkg
// Shared definitions for the DPLL loop sequencer:
//   - FSM state encodings (also visible on the state_o debug port)
//   - default K-counter modes and default divider ratios
//   - helper functions: divider ratio coercion and saturating event add
// ----------------------------------------------------------------------------
package dpll_loop_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_ACQUIRE = 3'd2,
      ST_TRACK   = 3'd3,
      ST_LOCKED  = 3'd4,
      ST_FAULT   = 3'd5
   } dpll_state_e;

   localparam logic [3:0] K_ACQ_DEF   = 4'd2;   // fast loop during acquisition
   localparam logic [3:0] K_TRACK_DEF = 4'd5;   // slow loop once tracking
   localparam logic [7:0] MULT_N_DEF  = 8'd128;
   localparam logic [7:0] H_DIV_DEF   = 8'd1;

   // A divide ratio of zero is meaningless for the dividers; treat it as 1.
   function automatic logic [7:0] coerce_ratio(input logic [7:0] req);
      logic [7:0] res;
      if (req == 8'd0) begin
         res = 8'd1;
      end else begin
         res = req;
      end
      return res;
   endfunction

   // Add 0..2 events to an 8-bit count, sticking at 255.
   function automatic logic [7:0] sat_add_events(input logic [7:0] cnt, input logic [1:0] inc);
      logic [8:0] sum;
      logic [7:0] res;
      sum = {1'b0, cnt} + {7'd0, inc};
      if (sum[8]) begin
         res = 8'hFF;
      end else begin
         res = sum[7:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/dpll_loop_sequencer_window_counter.sv
// ----------------------------------------------------------------------------
// dpll_loop_sequencer_window_counter
// Measurement-window timer plus saturating DLF event counter.
// The timer free-runs 0..WIN_CYCLES-1 and wraps; restart_i forces it (and the
// event count) back to zero for the next cycle.
// Ports:
//   clk_i       oscillator clock
//   reset_ni    asynchronous active-low reset
//   restart_i   restart the window (timer and events cleared)
//   carry_i     DLF carry pulse
//   borrow_i    DLF borrow pulse
//   win_done_o  high during the last cycle of a window
//   events_o    events of the current window, including this cycle's pulses
//   timer_o     current position inside the window
// ----------------------------------------------------------------------------
module dpll_loop_sequencer_window_counter
   import dpll_loop_sequencer_pkg::*;
#(
   parameter int WIN_CYCLES = 4096,
   parameter int TIMER_W    = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic               restart_i,
   input  logic               carry_i,
   input  logic               borrow_i,
   output logic               win_done_o,
   output logic [7:0]         events_o,
   output logic [TIMER_W-1:0] timer_o
);

   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WIN_CYCLES - 1);

   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [7:0]         events_q, events_d;
   logic [1:0]         inc_s;
   logic [7:0]         events_now_s;

   // Both pulses in one cycle count as two events.
   assign inc_s        = {carry_i & borrow_i, carry_i ^ borrow_i};
   assign events_now_s = sat_add_events(events_q, inc_s);
   assign win_done_o   = (timer_q == TIMER_LAST);
   assign events_o     = events_now_s;
   assign timer_o      = timer_q;

   // Next timer / event count: restart and window end both open a fresh window.
   always_comb begin
      timer_d  = timer_q;
      events_d = events_q;
      if (restart_i) begin
         timer_d  = '0;
         events_d = 8'd0;
      end else if (win_done_o) begin
         timer_d  = '0;
         events_d = 8'd0;
      end else begin
         timer_d  = timer_q + TIMER_W'(1);
         events_d = events_now_s;
      end
   end

   // Timer and event count registers.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         timer_q  <= '0;
         events_q <= 8'd0;
      end else begin
         timer_q  <= timer_d;
         events_q <= events_d;
      end
   end

endmodule

// File: rtl/dpll_loop_sequencer.sv
// ----------------------------------------------------------------------------
// dpll_loop_sequencer
// Configures and sequences the DPLL loop: CLEAR -> ACQUIRE (wide K) ->
// TRACK (narrow K) -> LOCKED. Lock is declared and lost by counting DLF
// carry/borrow events per measurement window.
// Optional feature macro: DPLL_SEQ_TIMEOUT_EN -- ACQUIRE gives up after
// TIMEOUT_WIN windows and parks in FAULT until abort. Without it the fault
// output is constant 0 and FAULT is unreachable.
// Ports:
//   clk_i         oscillator clock (same as DLF)
//   reset_ni      asynchronous active-low reset
//   start_i       1-cycle start pulse, honoured only in IDLE
//   abort_i       level; forces IDLE on the next edge from any state
//   cfg_mult_n_i  requested output divider N (latched on start)
//   cfg_h_i       requested oscillator pre-divider H (latched on start)
//   carry_i       DLF carry pulse
//   borrow_i      DLF borrow pulse
//   k_mode_o      K-counter mode to DLF
//   mult_n_o      N to output divider
//   h_div_o       H to pre-divider
//   dlf_enable_o  DLF enable
//   loop_clear_o  clear request to DLF/DCO/dividers
//   locked_o      lock indication
//   lock_lost_o   1-cycle pulse on LOCKED -> ACQUIRE
//   fault_o       acquisition timeout flag
//   state_o       current FSM state (debug)
//   win_events_o  event count of the last completed window (debug)
// All outputs are registered.
// ----------------------------------------------------------------------------
module dpll_loop_sequencer
   import dpll_loop_sequencer_pkg::*;
#(
   parameter int         WIN_CYCLES    = 4096,
   parameter logic [3:0] K_ACQ         = K_ACQ_DEF,
   parameter logic [3:0] K_TRACK       = K_TRACK_DEF,
   parameter int         ACQ_THRESH    = 8,
   parameter int         TRACK_THRESH  = 2,
   parameter int         LOCK_CNT      = 4,
   parameter int         UNLOCK_THRESH = 16,
   parameter int         CLEAR_CYCLES  = 16
`ifdef DPLL_SEQ_TIMEOUT_EN
   ,
   parameter int         TIMEOUT_WIN   = 64
`endif
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       start_i,
   input  logic       abort_i,
   input  logic [7:0] cfg_mult_n_i,
   input  logic [7:0] cfg_h_i,
   input  logic       carry_i,
   input  logic       borrow_i,
   output logic [3:0] k_mode_o,
   output logic [7:0] mult_n_o,
   output logic [7:0] h_div_o,
   output logic       dlf_enable_o,
   output logic       loop_clear_o,
   output logic       locked_o,
   output logic       lock_lost_o,
   output logic       fault_o,
   output logic [2:0] state_o,
   output logic [7:0] win_events_o
);

   localparam int TIMER_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
   localparam int GOOD_W  = $clog2(LOCK_CNT + 1);

   localparam logic [TIMER_W-1:0] CLEAR_LAST   = TIMER_W'(CLEAR_CYCLES - 1);
   localparam logic [GOOD_W-1:0]  LOCK_CNT_G   = GOOD_W'(LOCK_CNT);
   localparam logic [7:0]         ACQ_THR_E    = 8'(ACQ_THRESH);
   localparam logic [7:0]         TRACK_THR_E  = 8'(TRACK_THRESH);
   localparam logic [7:0]         UNLOCK_THR_E = 8'(UNLOCK_THRESH);

   dpll_state_e        state_q, state_d;
   logic [GOOD_W-1:0]  good_q, good_d;
   logic [GOOD_W-1:0]  good_inc_s;
   logic               latch_cfg_s;

   logic               win_done_s;
   logic [7:0]         events_s;
   logic [TIMER_W-1:0] timer_s;
   logic               restart_s;

   logic [3:0]         k_mode_q, k_mode_d;
   logic [7:0]         mult_n_q, h_div_q;
   logic               dlf_enable_q, dlf_enable_d;
   logic               loop_clear_q, loop_clear_d;
   logic               locked_q, locked_d;
   logic               lock_lost_q, lock_lost_d;
   logic               fault_q, fault_d;
   logic [7:0]         win_events_q;

`ifdef DPLL_SEQ_TIMEOUT_EN
   localparam int                TMO_W    = $clog2(TIMEOUT_WIN + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_WIN);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   // Every state change opens a fresh window so measurements never straddle
   // two loop configurations.
   assign restart_s  = (state_d != state_q);
   assign good_inc_s = good_q + GOOD_W'(1);

   dpll_loop_sequencer_window_counter #(
      .WIN_CYCLES (WIN_CYCLES),
      .TIMER_W    (TIMER_W)
   ) u_window (
      .clk_i      (clk_i),
      .reset_ni   (reset_ni),
      .restart_i  (restart_s),
      .carry_i    (carry_i),
      .borrow_i   (borrow_i),
      .win_done_o (win_done_s),
      .events_o   (events_s),
      .timer_o    (timer_s)
   );

   // Next-state logic: abort overrides everything; window decisions are
   // taken in the window's last cycle using that cycle's events too.
   always_comb begin
      state_d     = state_q;
      good_d      = good_q;
      latch_cfg_s = 1'b0;
`ifdef DPLL_SEQ_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif
      if (abort_i) begin
         state_d = ST_IDLE;
         good_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_d     = ST_CLEAR;
                  latch_cfg_s = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CLEAR: begin
               good_d = '0;
               if (timer_s == CLEAR_LAST) begin
                  state_d = ST_ACQUIRE;
               end else begin
                  state_d = ST_CLEAR;
               end
            end
            ST_ACQUIRE: begin
               if (win_done_s) begin
                  if (events_s <= ACQ_THR_E) begin
                     if (good_inc_s == LOCK_CNT_G) begin
                        state_d = ST_TRACK;
                        good_d  = '0;
                     end else begin
                        good_d = good_inc_s;
                     end
                  end else begin
                     good_d = '0;
                  end
`ifdef DPLL_SEQ_TIMEOUT_EN
                  // A window that achieves lock wins over the timeout.
                  tmo_d = tmo_q + TMO_W'(1);
                  if ((state_d == ST_ACQUIRE) && (tmo_d == TMO_LAST)) begin
                     state_d = ST_FAULT;
                  end else begin
                     state_d = state_d;
                  end
`endif
               end else begin
                  state_d = ST_ACQUIRE;
               end
            end
            ST_TRACK: begin
               if (win_done_s) begin
                  if (events_s > UNLOCK_THR_E) begin
                     state_d = ST_ACQUIRE;
                     good_d  = '0;
                  end else if (events_s <= TRACK_THR_E) begin
                     if (good_inc_s == LOCK_CNT_G) begin
                        state_d = ST_LOCKED;
                        good_d  = '0;
                     end else begin
                        good_d = good_inc_s;
                     end
                  end else begin
                     good_d = '0;
                  end
               end else begin
                  state_d = ST_TRACK;
               end
            end
            ST_LOCKED: begin
               if (win_done_s && (events_s > UNLOCK_THR_E)) begin
                  state_d = ST_ACQUIRE;
                  good_d  = '0;
               end else begin
                  state_d = ST_LOCKED;
               end
            end
            ST_FAULT: begin
               state_d = ST_FAULT;
            end
            default: begin
               state_d = ST_IDLE;
               good_d  = '0;
            end
         endcase
      end
`ifdef DPLL_SEQ_TIMEOUT_EN
      tmo_d = (state_d == ST_ACQUIRE) ? tmo_d : '0;
`endif
   end

   // Output values for the state being entered, so the registered outputs
   // line up with state_o.
   always_comb begin
      k_mode_d     = K_ACQ;
      dlf_enable_d = 1'b0;
      loop_clear_d = 1'b1;
      locked_d     = 1'b0;
      fault_d      = 1'b0;
      case (state_d)
         ST_IDLE, ST_CLEAR: begin
            k_mode_d     = K_ACQ;
            dlf_enable_d = 1'b0;
            loop_clear_d = 1'b1;
         end
         ST_ACQUIRE: begin
            k_mode_d     = K_ACQ;
            dlf_enable_d = 1'b1;
            loop_clear_d = 1'b0;
         end
         ST_TRACK: begin
            k_mode_d     = K_TRACK;
            dlf_enable_d = 1'b1;
            loop_clear_d = 1'b0;
         end
         ST_LOCKED: begin
            k_mode_d     = K_TRACK;
            dlf_enable_d = 1'b1;
            loop_clear_d = 1'b0;
            locked_d     = 1'b1;
         end
         ST_FAULT: begin
            k_mode_d     = K_ACQ;
            dlf_enable_d = 1'b0;
            loop_clear_d = 1'b1;
`ifdef DPLL_SEQ_TIMEOUT_EN
            fault_d      = 1'b1;
`else
            fault_d      = 1'b0;
`endif
         end
         default: begin
            k_mode_d     = K_ACQ;
            dlf_enable_d = 1'b0;
            loop_clear_d = 1'b1;
         end
      endcase
      lock_lost_d = (state_q == ST_LOCKED) && (state_d == ST_ACQUIRE);
   end

   // FSM state and good-window counter.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= ST_IDLE;
         good_q  <= '0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
      end
   end

`ifdef DPLL_SEQ_TIMEOUT_EN
   // ACQUIRE window counter for the acquisition timeout.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   // Divider configuration, captured only when a start is accepted.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         mult_n_q <= MULT_N_DEF;
         h_div_q  <= H_DIV_DEF;
      end else if (latch_cfg_s) begin
         mult_n_q <= coerce_ratio(cfg_mult_n_i);
         h_div_q  <= coerce_ratio(cfg_h_i);
      end
   end

   // Registered loop-control outputs and last-window event count.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         k_mode_q     <= K_ACQ;
         dlf_enable_q <= 1'b0;
         loop_clear_q <= 1'b1;
         locked_q     <= 1'b0;
         lock_lost_q  <= 1'b0;
         fault_q      <= 1'b0;
         win_events_q <= 8'd0;
      end else begin
         k_mode_q     <= k_mode_d;
         dlf_enable_q <= dlf_enable_d;
         loop_clear_q <= loop_clear_d;
         locked_q     <= locked_d;
         lock_lost_q  <= lock_lost_d;
         fault_q      <= fault_d;
         if (win_done_s) begin
            win_events_q <= events_s;
         end
      end
   end

   assign k_mode_o     = k_mode_q;
   assign mult_n_o     = mult_n_q;
   assign h_div_o      = h_div_q;
   assign dlf_enable_o = dlf_enable_q;
   assign loop_clear_o = loop_clear_q;
   assign locked_o     = locked_q;
   assign lock_lost_o  = lock_lost_q;
   assign fault_o      = fault_q;
   assign state_o      = state_q;
   assign win_events_o = win_events_q;

endmodule

// File: tb/tb_dpll_loop_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dpll_loop_sequencer
// Directed bench for dpll_loop_sequencer (WIN_CYCLES=64, CLEAR_CYCLES=16).
// A second instance with a 256-cycle window exercises event saturation.
// Expected values are queued when stimulus is applied and compared when the
// corresponding DUT output is due.
// ----------------------------------------------------------------------------
module tb_dpll_loop_sequencer;

   logic       clk = 1'b0;
   logic       reset_ni;
   logic       start, abort, carry, borrow;
   logic [7:0] cfg_n, cfg_h;
   logic [3:0] k_mode;
   logic [7:0] mult_n, h_div, win_ev;
   logic       dlf_en, loop_clr, locked, lock_lost, fault;
   logic [2:0] st;

   logic       s_carry, s_borrow;
   logic [3:0] s_k_mode;
   logic [7:0] s_mult_n, s_h_div, s_win_ev;
   logic       s_dlf_en, s_loop_clr, s_locked, s_lock_lost, s_fault;
   logic [2:0] s_st;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   dpll_loop_sequencer #(.WIN_CYCLES(64), .CLEAR_CYCLES(16)) u_dut (
      .clk_i(clk), .reset_ni(reset_ni), .start_i(start), .abort_i(abort),
      .cfg_mult_n_i(cfg_n), .cfg_h_i(cfg_h), .carry_i(carry), .borrow_i(borrow),
      .k_mode_o(k_mode), .mult_n_o(mult_n), .h_div_o(h_div), .dlf_enable_o(dlf_en),
      .loop_clear_o(loop_clr), .locked_o(locked), .lock_lost_o(lock_lost),
      .fault_o(fault), .state_o(st), .win_events_o(win_ev)
   );

   dpll_loop_sequencer #(.WIN_CYCLES(256), .CLEAR_CYCLES(16)) u_sat (
      .clk_i(clk), .reset_ni(reset_ni), .start_i(1'b0), .abort_i(1'b0),
      .cfg_mult_n_i(8'd0), .cfg_h_i(8'd0), .carry_i(s_carry), .borrow_i(s_borrow),
      .k_mode_o(s_k_mode), .mult_n_o(s_mult_n), .h_div_o(s_h_div), .dlf_enable_o(s_dlf_en),
      .loop_clear_o(s_loop_clr), .locked_o(s_locked), .lock_lost_o(s_lock_lost),
      .fault_o(s_fault), .state_o(s_st), .win_events_o(s_win_ev)
   );

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_v(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic observe(input logic [31:0] obs);
      exp_t e;
      vectors++;
      if (sb_q.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty observed=%0d", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
         end
      end
   endtask

   initial begin
      reset_ni = 1'b0; start = 1'b0; abort = 1'b0; carry = 1'b0; borrow = 1'b0;
      cfg_n = 8'd0; cfg_h = 8'd0; s_carry = 1'b0; s_borrow = 1'b0;
      tick(3);

      // Reset values
      expect_v("rst_state", 32'd0);   observe({29'd0, st});
      expect_v("rst_mult_n", 32'd128); observe({24'd0, mult_n});
      expect_v("rst_h_div", 32'd1);   observe({24'd0, h_div});
      expect_v("rst_clear", 32'd1);   observe({31'd0, loop_clr});
      expect_v("rst_enable", 32'd0);  observe({31'd0, dlf_en});
      expect_v("rst_k_mode", 32'd2);  observe({28'd0, k_mode});
      expect_v("rst_locked", 32'd0);  observe({31'd0, locked});
      expect_v("rst_fault", 32'd0);   observe({31'd0, fault});
      expect_v("rst_win_ev", 32'd0);  observe({24'd0, win_ev});

      // Release reset; saturation instance gets both pulses for 200 cycles
      reset_ni = 1'b1; s_carry = 1'b1; s_borrow = 1'b1;
      expect_v("sat_win_pre", 32'd0);
      expect_v("sat_win", 32'd255);
      tick(200);
      s_carry = 1'b0; s_borrow = 1'b0;
      tick(55);
      observe({24'd0, s_win_ev});
      tick(1);
      observe({24'd0, s_win_ev});
      expect_v("idle_state", 32'd0);  observe({29'd0, st});
      expect_v("idle_clear", 32'd1);  observe({31'd0, loop_clr});

      // Start with H=0 coerced to 1
      cfg_n = 8'd64; cfg_h = 8'd0; start = 1'b1;
      expect_v("clr_state", 32'd1); expect_v("clr_mult_n", 32'd64); expect_v("clr_h_div", 32'd1);
      expect_v("clr_clear", 32'd1); expect_v("clr_enable", 32'd0);
      tick(1);
      start = 1'b0;
      observe({29'd0, st}); observe({24'd0, mult_n}); observe({24'd0, h_div});
      observe({31'd0, loop_clr}); observe({31'd0, dlf_en});

      // start/cfg changes outside IDLE are ignored
      tick(3);
      start = 1'b1; cfg_n = 8'd99; cfg_h = 8'd9;
      tick(1);
      start = 1'b0;
      tick(11);
      expect_v("clr_last_state", 32'd1); observe({29'd0, st});
      expect_v("acq_state", 32'd2); expect_v("acq_k_mode", 32'd2); expect_v("acq_enable", 32'd1);
      expect_v("acq_clear", 32'd0); expect_v("acq_mult_n", 32'd64); expect_v("acq_h_div", 32'd1);
      tick(1);
      observe({29'd0, st}); observe({28'd0, k_mode}); observe({31'd0, dlf_en});
      observe({31'd0, loop_clr}); observe({24'd0, mult_n}); observe({24'd0, h_div});

      // Quiet loop: 4 windows to TRACK, 4 more to LOCKED
      expect_v("acq_hold", 32'd2);
      tick(255); observe({29'd0, st});
      expect_v("trk_state", 32'd3); expect_v("trk_k_mode", 32'd5); expect_v("trk_locked", 32'd0);
      tick(1); observe({29'd0, st}); observe({28'd0, k_mode}); observe({31'd0, locked});
      expect_v("trk_hold", 32'd3);
      tick(255); observe({29'd0, st});
      expect_v("lck_state", 32'd4); expect_v("lck_locked", 32'd1); expect_v("lck_k_mode", 32'd5);
      expect_v("lck_win_ev", 32'd0);
      tick(1); observe({29'd0, st}); observe({31'd0, locked}); observe({28'd0, k_mode});
      observe({24'd0, win_ev});

      // 17 borrows in one LOCKED window -> back to ACQUIRE with lock_lost pulse
      borrow = 1'b1; tick(17); borrow = 1'b0; tick(46);
      expect_v("lck_hold", 32'd4); expect_v("lck_hold_locked", 32'd1); expect_v("lck_no_lost", 32'd0);
      observe({29'd0, st}); observe({31'd0, locked}); observe({31'd0, lock_lost});
      expect_v("unl_state", 32'd2); expect_v("unl_locked", 32'd0); expect_v("unl_lost", 32'd1);
      expect_v("unl_win_ev", 32'd17); expect_v("unl_k_mode", 32'd2);
      tick(1);
      observe({29'd0, st}); observe({31'd0, locked}); observe({31'd0, lock_lost});
      observe({24'd0, win_ev}); observe({28'd0, k_mode});
      expect_v("unl_lost_end", 32'd0);
      tick(1); observe({31'd0, lock_lost});

      // Carry and borrow together for the remaining 63 cycles of the window
      carry = 1'b1; borrow = 1'b1;
      expect_v("dual_state", 32'd2); expect_v("dual_win_ev", 32'd126);
      tick(63);
      carry = 1'b0; borrow = 1'b0;
      observe({29'd0, st}); observe({24'd0, win_ev});

      // Exactly ACQ_THRESH (8) events per window still counts as good
      for (int w = 0; w < 4; w++) begin
         for (int i = 0; i < 64; i++) begin
            carry = (i < 8) ? 1'b1 : 1'b0;
            if ((w == 3) && (i == 63)) begin
               expect_v("acq8_hold", 32'd2); observe({29'd0, st});
            end
            tick(1);
         end
      end
      carry = 1'b0;
      expect_v("acq8_track", 32'd3); observe({29'd0, st});
      expect_v("acq8_win_ev", 32'd8); observe({24'd0, win_ev});

      // TRACK: 16 events stays, 17 events falls back to ACQUIRE (no lock_lost)
      for (int i = 0; i < 64; i++) begin
         carry = (i < 16) ? 1'b1 : 1'b0;
         tick(1);
      end
      expect_v("trk16_state", 32'd3); observe({29'd0, st});
      expect_v("trk16_win_ev", 32'd16); observe({24'd0, win_ev});
      for (int i = 0; i < 64; i++) begin
         carry = (i < 17) ? 1'b1 : 1'b0;
         tick(1);
      end
      carry = 1'b0;
      expect_v("trk17_state", 32'd2); observe({29'd0, st});
      expect_v("trk17_win_ev", 32'd17); observe({24'd0, win_ev});
      expect_v("trk17_no_lost", 32'd0); observe({31'd0, lock_lost});

      // Abort -> IDLE on the next edge
      abort = 1'b1;
      expect_v("abt_state", 32'd0); expect_v("abt_clear", 32'd1); expect_v("abt_enable", 32'd0);
      tick(1);
      abort = 1'b0;
      observe({29'd0, st}); observe({31'd0, loop_clr}); observe({31'd0, dlf_en});

      // Asynchronous reset mid-operation
      cfg_n = 8'd200; cfg_h = 8'd7; start = 1'b1;
      expect_v("r2_mult_n", 32'd200); expect_v("r2_h_div", 32'd7);
      tick(1);
      start = 1'b0;
      observe({24'd0, mult_n}); observe({24'd0, h_div});
      tick(3);
      #2;
      reset_ni = 1'b0;
      expect_v("ar_state", 32'd0); expect_v("ar_mult_n", 32'd128); expect_v("ar_h_div", 32'd1);
      expect_v("ar_clear", 32'd1);
      #1;
      observe({29'd0, st}); observe({24'd0, mult_n}); observe({24'd0, h_div});
      observe({31'd0, loop_clr});
      tick(1);
      reset_ni = 1'b1;

      // Restart with N=0 coerced to 1
      cfg_n = 8'd0; cfg_h = 8'd5; start = 1'b1;
      expect_v("r3_mult_n", 32'd1); expect_v("r3_h_div", 32'd5);
      tick(1);
      start = 1'b0;
      observe({24'd0, mult_n}); observe({24'd0, h_div});
      expect_v("r3_acq", 32'd2);
      tick(16); observe({29'd0, st});

`ifdef DPLL_SEQ_TIMEOUT_EN
      // 10 carries every window never qualifies -> FAULT after 64 windows
      for (int w = 0; w < 64; w++) begin
         for (int i = 0; i < 64; i++) begin
            carry = (i < 10) ? 1'b1 : 1'b0;
            if ((w == 63) && (i == 63)) begin
               expect_v("tmo_hold", 32'd2); observe({29'd0, st});
               expect_v("tmo_hold_fault", 32'd0); observe({31'd0, fault});
            end
            tick(1);
         end
      end
      carry = 1'b0;
      expect_v("tmo_state", 32'd5); observe({29'd0, st});
      expect_v("tmo_fault", 32'd1); observe({31'd0, fault});
      expect_v("tmo_clear", 32'd1); observe({31'd0, loop_clr});
      expect_v("tmo_enable", 32'd0); observe({31'd0, dlf_en});
`else
      // Without the timeout feature the same traffic just keeps acquiring
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 64; i++) begin
            carry = (i < 10) ? 1'b1 : 1'b0;
            tick(1);
         end
      end
      carry = 1'b0;
      expect_v("notmo_state", 32'd2); observe({29'd0, st});
      expect_v("notmo_fault", 32'd0); observe({31'd0, fault});
      expect_v("notmo_win_ev", 32'd10); observe({24'd0, win_ev});
`endif
      abort = 1'b1;
      expect_v("end_abt_state", 32'd0); expect_v("end_abt_fault", 32'd0);
      tick(1);
      abort = 1'b0;
      observe({29'd0, st}); observe({31'd0, fault});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
